// File: rtl/store_checker.sv
// store_checker: scoreboard that compares monitored bus stores against a preloaded queue of expected stores.
// Ports: clk/reset, bus monitor (MemWrite, DataAdr, WriteData), queue load (exp_push, exp_adr, exp_data), start,
//        status (exp_full, busy, done, pass, timeout, overflow), counters (match_cnt, err_cnt), first-mismatch capture (bad_adr, bad_data).
module store_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 1000,
    parameter bit STOP_ON_ERR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              exp_push,
    input  logic [ADDR_W-1:0] exp_adr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    output logic              exp_full,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overflow,
    output logic [15:0]       match_cnt,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] bad_adr,
    output logic [DATA_W-1:0] bad_data
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] qa [DEPTH];
    logic [DATA_W-1:0] qd [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count, cnt_n;
    logic [31:0]       cyc;
    logic              hit, ok, miss, stop, to_hit, push_ok;

    assign exp_full = (count == (PW+1)'(DEPTH));
    assign push_ok  = (state == IDLE) && exp_push && !exp_full;

    // A store is only scored while running with something to compare against.
    assign hit   = MemWrite && (state == RUN) && (count != '0);
    assign ok    = hit && (DataAdr == qa[head]) && (WriteData == qd[head]);
    assign miss  = hit && !ok;
    assign cnt_n = count - {{PW{1'b0}}, hit};
    assign stop  = miss && STOP_ON_ERR;
    // The pop is scored first: a queue drained this cycle beats the timeout.
    assign to_hit = (state == RUN) && (count != '0) && !stop &&
                    (cnt_n != '0) && (cyc == 32'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (count == '0)
                    state_n = (err_cnt == '0) ? PASS : FAIL;
                else if (stop || to_hit)
                    state_n = FAIL;
            end
            default: state_n = state;
        endcase
    end

    // Queue storage carries no reset; emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            qa[tail] <= exp_adr;
            qd[tail] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cyc       <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            bad_adr   <= '0;
            bad_data  <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == PASS) || (state_n == FAIL);
            pass  <= (state_n == PASS);
            if (to_hit) timeout <= 1'b1;
            if (state == IDLE) begin
                if (exp_push && exp_full) overflow <= 1'b1;
                if (push_ok) begin
                    tail  <= tail + 1'b1;
                    count <= count + 1'b1;
                end
                if (start) cyc <= '0;
            end
            if (state == RUN) begin
                cyc <= cyc + 1'b1;
                if (hit) begin
                    head  <= head + 1'b1;
                    count <= cnt_n;
                end
                if (ok && match_cnt != 16'hFFFF)
                    match_cnt <= match_cnt + 1'b1;
                if (miss) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
                    if (err_cnt == '0) begin
                        bad_adr  <= DataAdr;
                        bad_data <= WriteData;
                    end
                end
            end
        end
    end

endmodule
